// File: rtl/demux_l1_ctrl_pkg.sv
// Shared definitions for the demux layer-1 controller: one-hot state codes,
// default widths and the side-availability helper.
package demux_l1_ctrl_pkg;

  localparam int UMBRAL_W_DEF = 3;
  localparam int CNT_W_DEF    = 8;

  typedef enum logic [4:0] {
    ST_RESET  = 5'b00001,
    ST_INIT   = 5'b00010,
    ST_IDLE   = 5'b00100,
    ST_ACTIVE = 5'b01000,
    ST_ERROR  = 5'b10000
  } state_t;

  // Side s feeds downstream FIFOs s and s+2; it is usable only if neither is almost full.
  function automatic logic side_free(input logic [3:0] almost_full, input logic side);
    return !(almost_full[{1'b0, side}] | almost_full[{1'b1, side}]);
  endfunction

endpackage

// File: rtl/demux_l1_ctrl_if.sv
// Control/status bundle between the demux layer-1 controller and its environment
// (upstream FIFOs, downstream FIFOs and the demux datapath).
interface demux_l1_ctrl_if
  import demux_l1_ctrl_pkg::*;
#(
  parameter int UMBRAL_W = UMBRAL_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) ();

  logic                init;
  logic [UMBRAL_W-1:0] umbral_in;
  logic                valid_in;
  logic [3:0]          fifo_almost_full;
  logic [3:0]          fifo_empty;
  logic [3:0]          fifo_error;
  logic                pop;
  logic                selector;
  logic                valid_out;
  logic [UMBRAL_W-1:0] umbral_out;
  logic [4:0]          state;
  logic                idle;
  logic                error_out;
  logic [CNT_W-1:0]    stall_cnt;

  modport master (
    output init, umbral_in, valid_in, fifo_almost_full, fifo_empty, fifo_error,
    input  pop, selector, valid_out, umbral_out, state, idle, error_out, stall_cnt
  );

  modport slave (
    input  init, umbral_in, valid_in, fifo_almost_full, fifo_empty, fifo_error,
    output pop, selector, valid_out, umbral_out, state, idle, error_out, stall_cnt
  );

endinterface

// File: rtl/demux_l1_ctrl_rr_side_sel.sv
// Round-robin side chooser: prefers the side not used last, falls back to the
// other side when the preferred one is backpressured.
module rr_side_sel
  import demux_l1_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] almost_full,
  input  logic       take,
  output logic       choice,
  output logic       any_free
);

  logic last_sel_reg;
  logic pref;
  logic pref_free;
  logic other_free;

  assign pref       = ~last_sel_reg;
  assign pref_free  = side_free(almost_full, pref);
  assign other_free = side_free(almost_full, ~pref);
  assign choice     = pref_free ? pref : ~pref;
  assign any_free   = pref_free | other_free;

  // Reset value 1 makes the first accepted word go to side 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_sel_reg <= 1'b1;
    end else if (take) begin
      last_sel_reg <= choice;
    end
  end

endmodule

// File: rtl/demux_l1_ctrl.sv
// Sequencing FSM for the two-lane 1:2 demux layer: pops upstream word pairs,
// steers them round-robin around backpressure, distributes the threshold, flags errors.
module demux_l1_ctrl
  import demux_l1_ctrl_pkg::*;
#(
  parameter int UMBRAL_W = UMBRAL_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  demux_l1_ctrl_if.slave    bus
);

  state_t              state_reg;
  state_t              state_next;
  logic                selector_reg;
  logic                valid_out_reg;
  logic [UMBRAL_W-1:0] umbral_reg;
  logic [CNT_W-1:0]    stall_reg;
  logic                choice;
  logic                any_free;
  logic                pop;
  logic                stall_hit;
  logic                enter_init;

  rr_side_sel u_side_sel (
    .clk         (clk),
    .reset       (reset),
    .almost_full (bus.fifo_almost_full),
    .take        (pop),
    .choice      (choice),
    .any_free    (any_free)
  );

  assign pop        = (state_reg == ST_ACTIVE) & bus.valid_in & any_free;
  assign stall_hit  = (state_reg == ST_ACTIVE) & bus.valid_in & ~any_free;
  assign enter_init = (state_next == ST_INIT) & (state_reg != ST_INIT);

  // Errors override everything except leaving RESET; ERROR is left only through init.
  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_RESET) begin
      state_next = ST_INIT;
    end else if (|bus.fifo_error) begin
      state_next = ST_ERROR;
    end else begin
      case (state_reg)
        ST_ERROR:  if (bus.init) state_next = ST_INIT;
        ST_INIT:   if (!bus.init) state_next = ST_IDLE;
        ST_IDLE: begin
          if (bus.init)          state_next = ST_INIT;
          else if (bus.valid_in) state_next = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (bus.init)
            state_next = ST_INIT;
          else if (!bus.valid_in && (bus.fifo_empty == 4'b1111))
            state_next = ST_IDLE;
        end
        default:   state_next = ST_RESET;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_RESET;
      selector_reg  <= 1'b0;
      valid_out_reg <= 1'b0;
      umbral_reg    <= '0;
      stall_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      valid_out_reg <= pop;
      if (pop) begin
        selector_reg <= choice;
      end
      if ((state_reg == ST_INIT) && bus.init) begin
        umbral_reg <= bus.umbral_in;
      end
      // Entering INIT clears the counter even if a stall was seen the same cycle.
      if (enter_init) begin
        stall_reg <= '0;
      end else if (stall_hit && (stall_reg != {CNT_W{1'b1}})) begin
        stall_reg <= stall_reg + 1'b1;
      end
    end
  end

  assign bus.pop        = pop;
  assign bus.selector   = selector_reg;
  assign bus.valid_out  = valid_out_reg;
  assign bus.umbral_out = umbral_reg;
  assign bus.state      = state_reg;
  assign bus.idle       = (state_reg == ST_IDLE);
  assign bus.error_out  = (state_reg == ST_ERROR);
  assign bus.stall_cnt  = stall_reg;

endmodule

// File: tb/tb_demux_l1_ctrl.sv
// Directed plus randomized checks of demux_l1_ctrl against a cycle-level
// behavioural model of the sequencing rules.
module tb_demux_l1_ctrl;

  localparam int M_RESET  = 0;
  localparam int M_INIT   = 1;
  localparam int M_IDLE   = 2;
  localparam int M_ACTIVE = 3;
  localparam int M_ERROR  = 4;

  logic clk = 1'b0;
  logic reset;

  demux_l1_ctrl_if #(.UMBRAL_W(3), .CNT_W(8)) bus ();

  demux_l1_ctrl #(.UMBRAL_W(3), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int       m_st;
  bit       m_last;
  bit       m_sel;
  bit       m_vout;
  bit [2:0] m_umb;
  int       m_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit free_side(input int s);
    return !(bus.fifo_almost_full[s] | bus.fifo_almost_full[s+2]);
  endfunction

  function automatic bit model_pop();
    return !reset && (m_st == M_ACTIVE) && bus.valid_in && (free_side(0) || free_side(1));
  endfunction

  task automatic model_reset();
    m_st = M_RESET; m_last = 1'b1; m_sel = 1'b0; m_vout = 1'b0; m_umb = '0; m_stall = 0;
  endtask

  task automatic model_edge();
    int pref, ch, nxt;
    bit p;
    if (reset) begin
      model_reset();
      return;
    end
    p    = model_pop();
    pref = m_last ? 0 : 1;
    ch   = free_side(pref) ? pref : 1 - pref;
    if (p) begin
      m_sel = ch[0]; m_last = ch[0]; m_vout = 1'b1;
    end else begin
      m_vout = 1'b0;
    end
    if (m_st == M_ACTIVE && bus.valid_in && !free_side(0) && !free_side(1) && m_stall < 255)
      m_stall++;
    if (m_st == M_INIT && bus.init) m_umb = bus.umbral_in;
    nxt = m_st;
    if (m_st == M_RESET) nxt = M_INIT;
    else if (bus.fifo_error != 4'b0) nxt = M_ERROR;
    else if (m_st == M_ERROR) nxt = bus.init ? M_INIT : M_ERROR;
    else if (m_st == M_INIT) nxt = bus.init ? M_INIT : M_IDLE;
    else if (bus.init) nxt = M_INIT;
    else if (m_st == M_IDLE && bus.valid_in) nxt = M_ACTIVE;
    else if (m_st == M_ACTIVE && !bus.valid_in && bus.fifo_empty == 4'hF) nxt = M_IDLE;
    if (nxt == M_INIT && m_st != M_INIT) m_stall = 0;
    m_st = nxt;
  endtask

  task automatic check_regs();
    check("state", bus.state, 32'(1 << m_st));
    check("selector", bus.selector, m_sel);
    check("valid_out", bus.valid_out, m_vout);
    check("umbral_out", bus.umbral_out, m_umb);
    check("stall_cnt", bus.stall_cnt, m_stall);
    check("idle", bus.idle, m_st == M_IDLE);
    check("error_out", bus.error_out, m_st == M_ERROR);
  endtask

  // Inputs are driven before calling; pop is checked before the edge, registers after it.
  task automatic cycle();
    #1;
    check("pop", bus.pop, model_pop());
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
    @(negedge clk);
  endtask

  task automatic drive(input bit i, input bit v, input logic [3:0] af,
                       input logic [3:0] em, input logic [3:0] er);
    bus.init = i; bus.valid_in = v; bus.fifo_almost_full = af;
    bus.fifo_empty = em; bus.fifo_error = er;
  endtask

  initial begin
    reset = 1'b1;
    bus.umbral_in = 3'd0;
    drive(0, 0, 4'h0, 4'hF, 4'h0);
    model_reset();

    // Reset, then init with threshold 5.
    repeat (3) cycle();
    reset = 1'b0;
    bus.umbral_in = 3'd5;
    drive(1, 0, 4'h0, 4'hF, 4'h0);
    repeat (2) cycle();
    drive(0, 0, 4'h0, 4'hF, 4'h0);
    cycle();
    check("t1_state_idle", bus.state, 32'h04);
    check("t1_umbral", bus.umbral_out, 32'd5);

    // Free streaming: alternates 0,1,0,1 after the one-cycle IDLE->ACTIVE step.
    drive(0, 1, 4'h0, 4'h0, 4'h0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t2_sel_seq", bus.selector, i % 2);
      check("t2_valid_out", bus.valid_out, 1);
    end

    // Side 0 backpressured by FIFO 2: every accept lands on side 1.
    drive(0, 1, 4'b0100, 4'h0, 4'h0);
    repeat (4) begin
      cycle();
      check("t3_sel", bus.selector, 1);
    end
    check("t3_stall", bus.stall_cnt, 0);

    // Both sides backpressured long enough to saturate the counter.
    drive(0, 1, 4'b0011, 4'h0, 4'h0);
    repeat (300) cycle();
    check("t4_stall_sat", bus.stall_cnt, 255);
    check("t4_valid_out", bus.valid_out, 0);
    drive(0, 1, 4'h0, 4'h0, 4'h0);
    cycle();
    check("t4_resume_sel", bus.selector, 0);
    check("t4_resume_vo", bus.valid_out, 1);

    // Randomized traffic, backpressure, occasional init and errors.
    for (int n = 0; n < 400; n++) begin
      bus.umbral_in = 3'($urandom_range(0, 7));
      drive($urandom_range(0, 39) == 0,
            $urandom_range(0, 3) != 0,
            ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
            ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15)),
            ($urandom_range(0, 149) == 0) ? 4'($urandom_range(1, 15)) : 4'h0);
      if (m_st == M_ERROR && $urandom_range(0, 3) == 0) bus.init = 1'b1;
      cycle();
    end

    // Bring back to a streaming state, then hit a downstream error.
    drive(1, 0, 4'h0, 4'hF, 4'h0);
    repeat (2) cycle();
    drive(0, 1, 4'h0, 4'h0, 4'h0);
    repeat (4) cycle();
    drive(0, 1, 4'h0, 4'h0, 4'b1000);
    cycle();
    check("t5_state_err", bus.state, 32'h10);
    check("t5_error_out", bus.error_out, 1);
    drive(0, 1, 4'h0, 4'h0, 4'h0);
    #1;
    check("t5_pop_err", bus.pop, 0);
    repeat (3) cycle();
    drive(1, 0, 4'h0, 4'hF, 4'h0);
    cycle();
    check("t5_state_init", bus.state, 32'h02);
    check("t5_stall_clr", bus.stall_cnt, 0);
    drive(0, 0, 4'h0, 4'hF, 4'h0);
    cycle();

    // Asynchronous reset while a word is in flight.
    drive(0, 1, 4'h0, 4'h0, 4'h0);
    repeat (4) cycle();
    check("t6_vo_before", bus.valid_out, 1);
    reset = 1'b1;
    #1;
    model_reset();
    check("t6_async_state", bus.state, 32'h01);
    check("t6_async_vo", bus.valid_out, 0);
    check("t6_async_sel", bus.selector, 0);
    check("t6_async_pop", bus.pop, 0);
    check("t6_async_umb", bus.umbral_out, 0);
    @(negedge clk);
    cycle();
    reset = 1'b0;
    drive(1, 0, 4'h0, 4'hF, 4'h0);
    repeat (2) cycle();
    drive(0, 1, 4'h0, 4'h0, 4'h0);
    repeat (3) cycle();
    check("t6_first_sel", bus.selector, 0);
    check("t6_first_vo", bus.valid_out, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_l1_ctrl.md
Name: demux_l1_ctrl

Overview:
Control FSM that sequences the two-lane 1:2 demux layer. Both lanes share one `selector` and one `validEntrada`. Selector 0 routes to outputs 0/2; selector 1 routes to outputs 1/3. The block pops words from the upstream input FIFOs, chooses the destination side round-robin, and skips any side whose downstream FIFOs are almost full. It also distributes the almost-full threshold during init and flags downstream FIFO errors.

Parameters:
UMBRAL_W, 3, width of the almost-full threshold passed to downstream FIFOs
CNT_W, 8, width of the saturating stall counter

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
init  input  1  enter/stay in INIT and latch umbral_in
umbral_in  input  UMBRAL_W  threshold value latched during INIT
valid_in  input  1  upstream input FIFOs both non-empty (word pair available)
fifo_almost_full  input  4  almost-full flags of downstream FIFOs 0..3
fifo_empty  input  4  empty flags of downstream FIFOs 0..3
fifo_error  input  4  overflow/underflow flags of downstream FIFOs 0..3
pop  output  1  combinational read strobe to both upstream FIFOs
selector  output  1  registered demux select
valid_out  output  1  registered validEntrada to the demux layer
umbral_out  output  UMBRAL_W  registered threshold to downstream FIFOs
state  output  5  one-hot state: RESET=00001, INIT=00010, IDLE=00100, ACTIVE=01000, ERROR=10000
idle  output  1  high when state==IDLE
error_out  output  1  high when state==ERROR
stall_cnt  output  CNT_W  saturating count of cycles stalled by backpressure

Behaviour:
- Reset (async, any cycle, mid-transfer included):
  - state=RESET; selector=0, valid_out=0, umbral_out=0, stall_cnt=0.
  - Internal last_sel=1, so the first accepted word goes to side 0.
  - pop=0 while in RESET.
- Transitions, evaluated every clk in this priority order:
  - RESET -> INIT on the first clk after reset is released.
  - Any state except RESET: any bit of fifo_error=1 -> ERROR.
  - ERROR: sticky; leaves only via reset, or init=1 -> INIT.
  - INIT: umbral_out <= umbral_in every cycle while init=1; init=0 -> IDLE.
  - IDLE / ACTIVE: init=1 -> INIT. An in-flight valid_out still completes its one cycle.
  - IDLE -> ACTIVE when valid_in=1.
  - ACTIVE -> IDLE when valid_in=0 and fifo_empty==4'b1111.
- Side availability:
  - side0_free = !(fifo_almost_full[0] | fifo_almost_full[2]).
  - side1_free = !(fifo_almost_full[1] | fifo_almost_full[3]).
- Accept rule:
  - pop = (state==ACTIVE) & valid_in & (side0_free | side1_free).
  - pop is Mealy, same cycle. No pop in IDLE; the IDLE->ACTIVE transition costs one cycle.
- Side choice:
  - pref = ~last_sel. Choose pref if it is free, otherwise the other side.
  - On pop: selector <= choice, last_sel <= choice, valid_out <= 1.
  - Otherwise: valid_out <= 0 and selector holds.
- Latency: the upstream FIFO presents data one cycle after pop (synchronous read), aligned with the registered selector/valid_out. The demux adds one more cycle.
- Stall counter: stall_cnt increments when state==ACTIVE & valid_in & !side0_free & !side1_free. It saturates at all-ones and is cleared only by reset or entry to INIT.
- Simultaneous events:
  - fifo_error together with init: ERROR wins that cycle; INIT is entered on the next cycle if init is still high.
  - Almost-full asserting in the same cycle as a pop: the flags sampled in that cycle decide.

Decomposition:
- Shared package holds the state one-hot constants (ST_RESET..ST_ERROR) and the default UMBRAL_W/CNT_W.
- One natural sub-module, rr_side_sel: last_sel register plus the pref/free choice logic, emitting choice and any_free.
- FSM and counter stay in the top module.

Test Plan:
1. Reset high 3 cycles, then low, init=1 with umbral_in=3'd5 for 2 cycles, then init=0 -> state RESET->INIT->IDLE, umbral_out=5, all other outputs 0.
2. ACTIVE, no almost-full, valid_in=1 for 4 cycles -> pop=1 each cycle; selector sequence 0,1,0,1 one cycle later; valid_out=1 for 4 cycles.
3. fifo_almost_full=4'b0100 with valid_in=1 -> selector stays 1 on every accept, pop=1, stall_cnt=0.
4. fifo_almost_full=4'b0011 for 300 cycles with valid_in=1 -> pop=0, valid_out=0, stall_cnt saturates at 255; release flags -> resumes on side pref.
5. fifo_error[3]=1 mid-stream -> next cycle state=ERROR, error_out=1, pop=0; pulse init -> INIT, stall_cnt=0.
6. Assert reset during ACTIVE with valid_out=1 -> outputs cleared immediately without a clk edge; next accepted word goes to selector=0.
